// File: rtl/load_store_unit.sv
// Load/store unit: turns a single-cycle datapath load/store into a bus access
// through an IDLE -> BUSY -> DONE handshake. It builds byte enables and
// lane-replicated store data, and it sign/zero-extends load data.
// Optional feature macro: LSU_TIMEOUT_EN. When it is defined, a BUSY access
// that receives no mem_ack within TIMEOUT_CYCLES cycles is abandoned and
// bus_err is flagged.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] read_data_reg;
    logic        misaligned_reg;
    logic        bus_err_reg;
    logic        load_reg;
    logic        byte_reg;
    logic        half_reg;
    logic        zext_reg;
    logic [1:0]  off_reg;

    logic        access;
    logic        size_byte;
    logic        size_half;
    logic        aligned;
    logic [1:0]  off;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    // A timeout of zero cycles cannot be represented by the counter.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT_CYCLES must be at least 1");
    end

    assign access    = MemRead | MemWrite;
    assign off       = ALUResult[1:0];
    // funct3[1:0] encodes the size. Every encoding that is not byte or half
    // (011, 110, 111) is a word access.
    assign size_byte = (funct3[1:0] == 2'b00);
    assign size_half = (funct3[1:0] == 2'b01);
    assign aligned   = size_byte | (size_half & ~off[0]) |
                       (~size_byte & ~size_half & (off == 2'b00));

    // Build the store lane enables and replicate store data across the lanes.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteData;
        if (size_byte) begin
            be_next    = 4'b0001 << off;
            wdata_next = {4{WriteData[7:0]}};
        end else if (size_half) begin
            be_next    = 4'b0011 << off;
            wdata_next = {2{WriteData[15:0]}};
        end
    end

    // Select the addressed lane of the returned word and extend it to 32 bits.
    always_comb begin
        lane_byte = mem_rdata[{off_reg, 3'b000} +: 8];
        lane_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext  = mem_rdata;
        if (byte_reg) begin
            load_ext = zext_reg ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        end else if (half_reg) begin
            load_ext = zext_reg ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
        end
    end

    // The datapath is held while a request is detected in IDLE and for all of
    // BUSY. In DONE the signal drops so that the instruction retires.
    assign stall = Reset & (((state_reg == IDLE) & access) | (state_reg == BUSY));

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_reg;
`endif

    // Access FSM. All bus outputs, the flags and the load result are registered.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= IDLE;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
            mem_be_reg     <= 4'd0;
            read_data_reg  <= 32'd0;
            misaligned_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
            load_reg       <= 1'b0;
            byte_reg       <= 1'b0;
            half_reg       <= 1'b0;
            zext_reg       <= 1'b0;
            off_reg        <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_reg        <= '0;
`endif
        end else begin
            misaligned_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            state_reg     <= BUSY;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= MemWrite;
                            mem_addr_reg  <= {ALUResult[31:2], 2'b00};
                            mem_wdata_reg <= wdata_next;
                            mem_be_reg    <= be_next;
                            // A request with both MemRead and MemWrite set is a store.
                            load_reg      <= ~MemWrite;
                            byte_reg      <= size_byte;
                            half_reg      <= size_half;
                            zext_reg      <= funct3[2];
                            off_reg       <= off;
`ifdef LSU_TIMEOUT_EN
                            cnt_reg       <= '0;
`endif
                        end else begin
                            state_reg      <= DONE;
                            read_data_reg  <= 32'd0;
                            misaligned_reg <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state_reg   <= DONE;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        mem_be_reg  <= 4'd0;
                        if (load_reg) begin
                            read_data_reg <= load_ext;
                        end
`ifdef LSU_TIMEOUT_EN
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= DONE;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        mem_be_reg  <= 4'd0;
                        bus_err_reg <= 1'b1;
                        if (load_reg) begin
                            read_data_reg <= 32'd0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
`endif
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_be     = mem_be_reg;
    assign ReadData   = read_data_reg;
    assign misaligned = misaligned_reg;
`ifdef LSU_TIMEOUT_EN
    assign bus_err    = bus_err_reg;
`else
    assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. It runs directed and random loads and stores
// and checks them against a behavioural model of the byte-lane and extension
// rules. The timeout scenario is built only when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        stall;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rd = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .stall(stall), .misaligned(misaligned),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        int v  = ((1 << sz) - 1) << (a % 4);
        if (sz == 4) v = 15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = size_of(f3);
        if (sz == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int sz = size_of(f3);
        logic [31:0] sh = rd >> (8 * (a % 4));
        logic signed [7:0]  b = sh[7:0];
        logic signed [15:0] h = sh[15:0];
        logic signed [31:0] r;
        if (sz == 1) begin
            r = b;
            return f3[2] ? (sh & 32'hFF) : r;
        end
        if (sz == 2) begin
            r = h;
            return f3[2] ? (sh & 32'hFFFF) : r;
        end
        return rd;
    endfunction

    // ---------------- generic access driver/checker ----------------
    // delay < 0 means that no ack is ever given.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdat, input int delay,
                             input logic ack_in_done, input string name);
        int  sz = size_of(f3);
        bit  al = ((addr % sz) == 0);
        bit  st = wr;
        bit  to_exp = 0;
        int  exp_busy, exp_stall, busy, stall_cyc;
        bit  done = 0;
`ifdef LSU_TIMEOUT_EN
        to_exp = al && (delay < 0 || delay >= TO);
`endif
        exp_busy  = !al ? 0 : (to_exp ? TO : delay + 1);
        exp_stall = 1 + exp_busy;
        busy = 0;
        stall_cyc = 0;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (stall) stall_cyc++;
            if (mem_req) begin
                busy++;
                checks++;
                if (mem_addr !== {addr[31:2], 2'b00} || mem_be !== model_be(f3, addr) ||
                    mem_we !== st || (st && mem_wdata !== model_wdata(f3, wd))) begin
                    failures++;
                    $display("FAIL %s bus: addr=%h be=%b we=%b wdata=%h want addr=%h be=%b we=%b wdata=%h",
                             name, mem_addr, mem_be, mem_we, mem_wdata, {addr[31:2], 2'b00},
                             model_be(f3, addr), st, model_wdata(f3, wd));
                end
                if (delay >= 0 && busy == delay + 1) begin
                    mem_ack = 1'b1; mem_rdata = rdat;
                end
            end else begin
                checks++;
                if (mem_be !== 4'd0) begin
                    failures++;
                    $display("FAIL %s be_idle: got %b want 0000", name, mem_be);
                end
            end
            if (stall) begin
                checks++;
                if (misaligned !== 1'b0 || bus_err !== 1'b0) begin
                    failures++;
                    $display("FAIL %s early_flag: misaligned=%b bus_err=%b want 0 0", name, misaligned, bus_err);
                end
            end else begin
                done = 1;
                if (!al) exp_rd = 32'd0;
                else if (!st) exp_rd = to_exp ? 32'd0 : model_load(f3, addr, rdat);
                checks++;
                if (ReadData !== exp_rd || misaligned !== !al || bus_err !== to_exp || mem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done: rd=%h mis=%b err=%b req=%b want rd=%h mis=%b err=%b req=0",
                             name, ReadData, misaligned, bus_err, mem_req, exp_rd, !al, to_exp);
                end
                if (ack_in_done) begin
                    mem_ack = 1'b1; mem_rdata = ~rdat;
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: access never completed", name);
        end
        checks++;
        if (stall_cyc != exp_stall || busy != exp_busy) begin
            failures++;
            $display("FAIL %s latency: stall=%0d busy=%0d want stall=%0d busy=%0d",
                     name, stall_cyc, busy, exp_stall, exp_busy);
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || ReadData !== exp_rd) begin
            failures++;
            $display("FAIL %s reissue: stall=%b req=%b rd=%h want 0 0 %h", name, stall, mem_req, ReadData, exp_rd);
        end
        $display("txn %s rd=%b wr=%b f3=%b addr=%h stall=%0d ReadData=%h", name, rd, wr, f3, addr, stall_cyc, ReadData);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
        ALUResult = 32'h100; WriteData = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (stall !== 0 || mem_req !== 0 || mem_we !== 0 || mem_be !== 0 || mem_addr !== 0 ||
            mem_wdata !== 0 || ReadData !== 0 || misaligned !== 0 || bus_err !== 0) begin
            failures++;
            $display("FAIL reset: stall=%b req=%b we=%b be=%b addr=%h wdata=%h rd=%h mis=%b err=%b want all 0",
                     stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadData, misaligned, bus_err);
        end
        MemRead = 1'b0;
        Reset = 1'b1;
        exp_rd = 32'd0;
        $display("txn reset");
    endtask

    task automatic test_directed();
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, "lw_0x100");
        checks++;
        if (exp_rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lw_model: got %h want deadbeef", exp_rd);
        end
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0011, 0, 0, "lb_0x103");
        checks++;
        if (ReadData !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL lb_value: got %h want ffffff80", ReadData);
        end
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0011, 0, 0, "lbu_0x103");
        checks++;
        if (ReadData !== 32'h00000080) begin
            failures++;
            $display("FAIL lbu_value: got %h want 00000080", ReadData);
        end
        do_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF0011, 0, 0, "lhu_0x102");
        checks++;
        if (ReadData !== 32'h000080FF) begin
            failures++;
            $display("FAIL lhu_value: got %h want 000080ff", ReadData);
        end
        do_access(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0, 0, "sb_0x201");
        do_access(0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0, 1, 0, "sh_0x202");
        do_access(1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h11111111, 0, 0, "rw_as_store");
        do_access(1, 0, 3'b111, 32'h208, 32'h0, 32'h8765_4321, 0, 0, "f3_111_word");
    endtask

    task automatic test_misaligned();
        do_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, "lw_mis_0x102");
        do_access(0, 1, 3'b001, 32'h203, 32'h12345678, 32'h0, 0, 0, "sh_mis_0x203");
        do_access(1, 0, 3'b110, 32'h301, 32'h0, 32'h0, 0, 0, "f3_110_mis");
    endtask

    task automatic test_idle_ack();
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 0 || mem_req !== 0 || ReadData !== exp_rd) begin
            failures++;
            $display("FAIL idle_ack: stall=%b req=%b rd=%h want 0 0 %h", stall, mem_req, ReadData, exp_rd);
        end
        $display("txn idle_ack ReadData=%h", ReadData);
    endtask

    task automatic test_reset_abort();
        int busy = 0;
        do_access(1, 0, 3'b010, 32'h400, 32'h0, 32'h0BAD_F00D, 5, 0, "lw_delay5");
        @(posedge clk); #1;
        MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h500;
        for (int c = 0; c < 10 && busy < 3; c++) begin
            @(negedge clk);
            if (mem_req) busy++;
        end
        #2 Reset = 1'b0;
        #1;
        exp_rd = 32'd0;
        checks++;
        if (mem_req !== 0 || stall !== 0 || ReadData !== 0 || mem_be !== 0 || busy != 3) begin
            failures++;
            $display("FAIL abort: req=%b stall=%b rd=%h be=%b busy=%0d want 0 0 0 0000 3",
                     mem_req, stall, ReadData, mem_be, busy);
        end
        @(posedge clk); #1;
        MemRead = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 0 || stall !== 0 || ReadData !== 0 || misaligned !== 0) begin
                failures++;
                $display("FAIL late_ack: req=%b stall=%b rd=%h mis=%b want 0 0 0 0",
                         mem_req, stall, ReadData, misaligned);
            end
        end
        $display("txn reset_abort ReadData=%h", ReadData);
        do_access(1, 0, 3'b001, 32'h502, 32'h0, 32'h7FFF_8001, 0, 0, "lh_after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int rw = $urandom_range(1, 3);
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rv = $urandom;
            int dl = $urandom_range(0, 4);
            logic ad = 1'($urandom_range(0, 1));
            do_access(rw[0], rw[1], f3, a, wd, rv, dl, ad, $sformatf("rand%0d", i));
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        do_access(0, 1, 3'b010, 32'h600, 32'h1234, 32'h0, -1, 0, "sw_timeout");
        do_access(1, 0, 3'b010, 32'h604, 32'h0, 32'h0, -1, 0, "lw_timeout");
        do_access(1, 0, 3'b010, 32'h608, 32'h0, 32'hA5A5_5A5A, TO - 1, 0, "lw_last_cycle_ack");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_idle_ack();
        test_reset_abort();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
